// File: rtl/srambank_burst_master.sv
// Burst read/write sequencer for a 1024x64 srambank macro. It turns valid/ready
// commands and data streams into single-cycle bank strobes.
module srambank_burst_master #(
    parameter int AW = 10,
    parameter int DW = 64,
    parameter int LW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    // Handshake rule on every channel: a transfer happens at the rising edge
    // where valid and ready are both high; valid never waits on ready.
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_write,
    input  logic [AW-1:0] req_addr,
    input  logic [LW-1:0] req_len,
    input  logic          wd_valid,
    output logic          wd_ready,
    input  logic [DW-1:0] wd_data,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data,
    output logic          rsp_last,
    output logic          wr_done,
    output logic [AW-1:0] ADDRESS,
    output logic [DW-1:0] wd,
    output logic          banksel,
    output logic          read,
    output logic          write,
    input  logic [DW-1:0] dataout,
    output logic [1:0]    dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WR     = 2'd1,
        RISSUE = 2'd2,
        RDATA  = 2'd3
    } state_t;

    state_t        state;
    logic [AW-1:0] addr;
    logic [LW-1:0] cnt;
    logic          next_read;

    // addr tracks the address of the last read issued, so follow-on reads use addr+1.
    assign next_read = (state == RDATA) && rsp_ready && (cnt != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            addr    <= '0;
            cnt     <= '0;
            wr_done <= 1'b0;
        end else begin
            wr_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr  <= req_addr;
                        cnt   <= req_len;
                        state <= req_write ? WR : RISSUE;
                    end
                end
                WR: begin
                    if (wd_valid) begin
                        addr <= addr + 1'b1;
                        if (cnt == '0) begin
                            state   <= IDLE;
                            wr_done <= 1'b1;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                end
                RISSUE: begin
                    state <= RDATA;
                end
                RDATA: begin
                    if (rsp_ready) begin
                        if (cnt == '0) begin
                            state <= IDLE;
                        end else begin
                            addr <= addr + 1'b1;
                            cnt  <= cnt - 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        req_ready = rst_n && (state == IDLE);
        wd_ready  = (state == WR);
        write     = (state == WR) && wd_valid;
        read      = (state == RISSUE) || next_read;
        banksel   = read || write;
        ADDRESS   = next_read ? addr + 1'b1 : addr;
        wd        = wd_data;
        rsp_valid = (state == RDATA);
        rsp_data  = dataout;
        rsp_last  = (state == RDATA) && (cnt == '0);
        dbg_state = state;
    end

endmodule

// File: tb/tb_srambank_burst_master.sv
// Directed bench for srambank_burst_master with a behavioural bank model
// and an independent expected-memory array.
module tb_srambank_burst_master;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [9:0]  req_addr;
    logic [3:0]  req_len;
    logic        wd_valid;
    logic        wd_ready;
    logic [63:0] wd_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_data;
    logic        rsp_last;
    logic        wr_done;
    logic [9:0]  ADDRESS;
    logic [63:0] wd;
    logic        banksel;
    logic        read;
    logic        write;
    logic [63:0] dataout;
    logic [1:0]  dbg_state;

    int checks   = 0;
    int failures = 0;
    int rd_strobes = 0;
    int wr_strobes = 0;
    int both_strobes = 0;

    logic [63:0] bank_mem [1024];
    logic [63:0] exp_mem  [1024];

    srambank_burst_master dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_len(req_len),
        .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_last(rsp_last), .wr_done(wr_done),
        .ADDRESS(ADDRESS), .wd(wd), .banksel(banksel), .read(read), .write(write),
        .dataout(dataout), .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // behavioural bank: latches read data, holds it until the next read
    always @(posedge clk) begin
        if (banksel && write) begin
            bank_mem[ADDRESS] <= wd;
            wr_strobes <= wr_strobes + 1;
        end
        if (banksel && read) begin
            dataout <= bank_mem[ADDRESS];
            rd_strobes <= rd_strobes + 1;
        end
        if (read && write) both_strobes <= both_strobes + 1;
    end

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_len = '0;
        wd_valid = 1'b0; wd_data = '0; rsp_ready = 1'b0;
        #12;
        checks++;
        if ({banksel, read, write, rsp_valid, rsp_last, wd_ready, wr_done} !== 7'b0) begin
            failures++;
            $display("FAIL reset_outputs: got %b want 0000000",
                     {banksel, read, write, rsp_valid, rsp_last, wd_ready, wr_done});
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b1 || dbg_state !== 2'd0) begin
            failures++;
            $display("FAIL reset_idle: req_ready=%b state=%0d want 1/0", req_ready, dbg_state);
        end
        @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge+1 of the wr_done cycle.
    task automatic write_burst(input logic [9:0] a, input logic [3:0] len,
                               input logic [63:0] base, input int gap_beat, input int gap_cycles);
        logic [9:0] ea;
        int w0;
        w0 = wr_strobes;
        req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_len = len;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL wr_accept: req_ready=%b want 1", req_ready);
        end
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            if (i == gap_beat) begin
                for (int g = 0; g < gap_cycles; g++) begin
                    wd_valid = 1'b0;
                    #1;
                    checks++;
                    if (write !== 1'b0 || banksel !== 1'b0 || wd_ready !== 1'b1) begin
                        failures++;
                        $display("FAIL wr_bubble: write=%b banksel=%b wd_ready=%b want 0/0/1",
                                 write, banksel, wd_ready);
                    end
                    @(negedge clk);
                end
            end
            ea = a + 10'(i);
            wd_valid = 1'b1;
            wd_data = base + 64'(i);
            #1;
            checks++;
            if (write !== 1'b1 || read !== 1'b0 || banksel !== 1'b1 || ADDRESS !== ea || wd !== wd_data) begin
                failures++;
                $display("FAIL wr_beat%0d: write=%b read=%b addr=%h wd=%h want 1/0 addr=%h wd=%h",
                         i, write, read, ADDRESS, wd, ea, wd_data);
            end
            exp_mem[ea] = wd_data;
            @(negedge clk);
        end
        wd_valid = 1'b0;
        #1;
        checks++;
        if (wr_done !== 1'b1 || req_ready !== 1'b1 || write !== 1'b0) begin
            failures++;
            $display("FAIL wr_done: wr_done=%b req_ready=%b write=%b want 1/1/0", wr_done, req_ready, write);
        end
        checks++;
        if (wr_strobes - w0 !== int'(len) + 1) begin
            failures++;
            $display("FAIL wr_count: got %0d want %0d", wr_strobes - w0, int'(len) + 1);
        end
    endtask

    // Called at a negedge(+1); returns at the negedge+1 of the first IDLE cycle.
    task automatic read_burst(input logic [9:0] a, input logic [3:0] len,
                              input int stall_beat, input int stall_cycles);
        logic [9:0] ea;
        int r0;
        r0 = rd_strobes;
        req_valid = 1'b1; req_write = 1'b0; req_addr = a; req_len = len;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL rd_accept: req_ready=%b want 1", req_ready);
        end
        @(negedge clk);
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        #1;
        checks++;
        if (read !== 1'b1 || write !== 1'b0 || ADDRESS !== a || rsp_valid !== 1'b0 || wr_done !== 1'b0) begin
            failures++;
            $display("FAIL rd_issue: read=%b write=%b addr=%h rsp_valid=%b wr_done=%b want 1/0 %h/0/0",
                     read, write, ADDRESS, rsp_valid, wr_done, a);
        end
        @(negedge clk);
        for (int i = 0; i <= int'(len); i++) begin
            ea = a + 10'(i);
            if (i == stall_beat) begin
                for (int s = 0; s < stall_cycles; s++) begin
                    rsp_ready = 1'b0;
                    #1;
                    checks++;
                    if (rsp_valid !== 1'b1 || rsp_data !== exp_mem[ea] || read !== 1'b0) begin
                        failures++;
                        $display("FAIL rd_stall%0d: valid=%b data=%h read=%b want 1 %h 0",
                                 i, rsp_valid, rsp_data, read, exp_mem[ea]);
                    end
                    @(negedge clk);
                end
            end
            rsp_ready = 1'b1;
            #1;
            checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== exp_mem[ea] || rsp_last !== (i == int'(len))) begin
                failures++;
                $display("FAIL rd_beat%0d: valid=%b data=%h last=%b want 1 %h %b",
                         i, rsp_valid, rsp_data, rsp_last, exp_mem[ea], i == int'(len));
            end
            if (i < int'(len)) begin
                checks++;
                if (read !== 1'b1 || ADDRESS !== ea + 10'd1) begin
                    failures++;
                    $display("FAIL rd_next%0d: read=%b addr=%h want 1 %h", i, read, ADDRESS, ea + 10'd1);
                end
            end
            @(negedge clk);
        end
        rsp_ready = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rd_strobes - r0 !== int'(len) + 1) begin
            failures++;
            $display("FAIL rd_end: rsp_valid=%b req_ready=%b strobes=%0d want 0/1/%0d",
                     rsp_valid, req_ready, rd_strobes - r0, int'(len) + 1);
        end
    endtask

    task automatic test_write_burst();
        write_burst(10'h010, 4'd3, 64'h0000_0000_0000_00A0, -1, 0);
    endtask

    task automatic test_read_back();
        read_burst(10'h010, 4'd3, -1, 0);
    endtask

    task automatic test_backpressure();
        read_burst(10'h010, 4'd3, 1, 3);
    endtask

    task automatic test_wrap();
        write_burst(10'h3FF, 4'd2, 64'hDEAD_BEEF_0000_0010, -1, 0);
        read_burst(10'h3FF, 4'd2, -1, 0);
    endtask

    task automatic test_bubbles();
        write_burst(10'h100, 4'd1, 64'h1234_5678_9ABC_0000, 1, 2);
        read_burst(10'h100, 4'd1, 0, 1);
    endtask

    task automatic test_reset_mid_read();
        req_valid = 1'b1; req_write = 1'b0; req_addr = 10'h010; req_len = 4'd7;
        @(negedge clk);
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== exp_mem[10'h010 + 10'(i)] || rsp_last !== 1'b0) begin
                failures++;
                $display("FAIL rst_rd_beat%0d: valid=%b data=%h last=%b want 1 %h 0",
                         i, rsp_valid, rsp_data, rsp_last, exp_mem[10'h010 + 10'(i)]);
            end
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || read !== 1'b0 || banksel !== 1'b0 || rsp_last !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_read: valid=%b read=%b banksel=%b last=%b want 0000",
                     rsp_valid, read, banksel, rsp_last);
        end
        rsp_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b1 || dbg_state !== 2'd0 || wr_done !== 1'b0) begin
            failures++;
            $display("FAIL rst_release: req_ready=%b state=%0d wr_done=%b want 1/0/0",
                     req_ready, dbg_state, wr_done);
        end
        @(negedge clk);
        read_burst(10'h012, 4'd0, -1, 0);
    endtask

    task automatic test_exclusive_strobes();
        checks++;
        if (both_strobes !== 0) begin
            failures++;
            $display("FAIL strobe_overlap: got %0d cycles want 0", both_strobes);
        end
    endtask

    initial begin
        test_reset();
        test_write_burst();
        test_read_back();
        test_backpressure();
        test_wrap();
        test_bubbles();
        test_reset_mid_read();
        test_exclusive_strobes();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
